// File: rtl/ffa_pkg.sv
// Shared types for the flip-flop-array command sequencer: widths, FSM states,
// the queued command format and the dispatch decision used by the FSM.
package ffa_pkg;

    localparam int FFA_AW = 3;
    localparam int FFA_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CAPT  = 3'd3,
        ST_HOLD  = 3'd4
    } ffa_state_e;

    typedef struct packed {
        logic              write;
        logic [FFA_AW-1:0] addr;
        logic [FFA_DW-1:0] wdata;
    } ffa_cmd_t;

    localparam ffa_cmd_t CMD_ZERO = '{write: 1'b0, addr: {FFA_AW{1'b0}}, wdata: {FFA_DW{1'b0}}};

    // Next state when the sequencer is free to issue: take the FIFO head, if any.
    function automatic ffa_state_e dispatch(input logic empty, input ffa_cmd_t head);
        ffa_state_e st;
        if (empty) begin
            st = ST_IDLE;
        end else if (head.write) begin
            st = ST_WRITE;
        end else begin
            st = ST_READ;
        end
        return st;
    endfunction

endpackage

// File: rtl/ffa_cmd_fifo.sv
// In-order command FIFO. Pointers carry one extra MSB so full and empty can be
// told apart when the index bits match.
module ffa_cmd_fifo
    import ffa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  ffa_cmd_t                 din,
    input  logic                     pop,
    output ffa_cmd_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wptr_r;
    logic [PW:0] rptr_r;
    ffa_cmd_t    mem_r [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
    assign count = wptr_r - rptr_r;
    assign head  = mem_r[rptr_r[PW-1:0]];

    // Entry storage: write the pushed command at the write pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= CMD_ZERO;
            end
        end else if (do_push_s) begin
            mem_r[wptr_r[PW-1:0]] <= din;
        end
    end

    // Pointer advance; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_r <= {(PW+1){1'b0}};
            rptr_r <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + {{PW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ffa_cmd_sequencer.sv
// Front-end for the 8x8 flip-flop array: queues commands, issues them as
// single-cycle registered strobes, returns read data with a written-since-reset tag.
module ffa_cmd_sequencer
    import ffa_pkg::*;
#(
    parameter int AW    = FFA_AW,
    parameter int DW    = FFA_DW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_init,
    output logic          arr_wr,
    output logic          arr_rd,
    output logic [AW-1:0] arr_addr,
    output logic [DW-1:0] arr_din,
    input  logic [DW-1:0] arr_dout,
    input  logic          arr_error,
    output logic          err_sticky,
    input  logic          err_clr,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    ffa_cmd_t        cmd_s;
    ffa_cmd_t        head_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   count_s;

    ffa_state_e      state_r;
    ffa_state_e      next_state_s;
    logic            run_r;

    logic            arr_wr_r;
    logic            arr_rd_r;
    logic [AW-1:0]   arr_addr_r;
    logic [DW-1:0]   arr_din_r;
    logic            rsp_valid_r;
    logic [DW-1:0]   rsp_rdata_r;
    logic [AW-1:0]   rsp_addr_r;
    logic            rsp_init_r;
    logic            err_r;
    logic [2**AW-1:0] written_r;

    logic            arr_wr_d_s;
    logic            arr_rd_d_s;
    logic [AW-1:0]   arr_addr_d_s;
    logic [DW-1:0]   arr_din_d_s;
    logic            rsp_valid_d_s;
    logic            capt_s;
    logic            err_set_s;

    assign cmd_s.write = cmd_write;
    assign cmd_s.addr  = cmd_addr;
    assign cmd_s.wdata = cmd_wdata;

    // run_r keeps cmd_ready low while reset is asserted and until the first clock after it.
    assign cmd_ready = run_r && !full_s;
    assign push_s    = cmd_valid && cmd_ready;
    assign busy      = (count_s != {CW{1'b0}}) || (state_r != ST_IDLE);

    assign arr_wr     = arr_wr_r;
    assign arr_rd     = arr_rd_r;
    assign arr_addr   = arr_addr_r;
    assign arr_din    = arr_din_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_addr   = rsp_addr_r;
    assign rsp_init   = rsp_init_r;
    assign err_sticky = err_r;

    ffa_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .din    (cmd_s),
        .pop    (pop_s),
        .head   (head_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (count_s)
    );

    // Accept-enable flag: rises on the first clock after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: issue from IDLE/WRITE, a read walks READ->CAPT->HOLD, HOLD waits for the consumer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_WRITE: next_state_s = dispatch(empty_s, head_s);
            ST_READ:           next_state_s = ST_CAPT;
            ST_CAPT:           next_state_s = ST_HOLD;
            ST_HOLD: begin
                if (rsp_ready) begin
                    next_state_s = dispatch(empty_s, head_s);
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default:           next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered array/response signals; entering WRITE or READ pops the head.
    always_comb begin
        pop_s         = (next_state_s == ST_WRITE) || (next_state_s == ST_READ);
        arr_wr_d_s    = (next_state_s == ST_WRITE);
        arr_rd_d_s    = (next_state_s == ST_READ);
        rsp_valid_d_s = (next_state_s == ST_HOLD);
        capt_s        = (state_r == ST_CAPT);
        if (pop_s) begin
            arr_addr_d_s = head_s.addr;
        end else begin
            arr_addr_d_s = arr_addr_r;
        end
        if (next_state_s == ST_WRITE) begin
            arr_din_d_s = head_s.wdata;
        end else begin
            arr_din_d_s = arr_din_r;
        end
        // An unwritten location must read back as zero; anything else is an array fault.
        err_set_s = arr_error ||
                    (capt_s && !written_r[arr_addr_r] && (arr_dout != {DW{1'b0}}));
    end

    // Registered array strobes, address/data and response-valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arr_wr_r    <= 1'b0;
            arr_rd_r    <= 1'b0;
            arr_addr_r  <= {AW{1'b0}};
            arr_din_r   <= {DW{1'b0}};
            rsp_valid_r <= 1'b0;
        end else begin
            arr_wr_r    <= arr_wr_d_s;
            arr_rd_r    <= arr_rd_d_s;
            arr_addr_r  <= arr_addr_d_s;
            arr_din_r   <= arr_din_d_s;
            rsp_valid_r <= rsp_valid_d_s;
        end
    end

    // Response capture in CAPT: arr_addr still holds the read address issued in READ.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_rdata_r <= {DW{1'b0}};
            rsp_addr_r  <= {AW{1'b0}};
            rsp_init_r  <= 1'b0;
        end else if (capt_s) begin
            rsp_rdata_r <= arr_dout;
            rsp_addr_r  <= arr_addr_r;
            rsp_init_r  <= written_r[arr_addr_r];
        end
    end

    // Written-since-reset bitmap, marked when a write is popped for issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            written_r <= {(2**AW){1'b0}};
        end else if (pop_s && head_s.write) begin
            written_r[head_s.addr] <= 1'b1;
        end
    end

    // Sticky fault flag; a new fault wins over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ffa_cmd_sequencer.sv
// Bench for ffa_cmd_sequencer: emulates the flip-flop array, keeps a command-order
// model of issue and responses, and adds directed literal checks.
module tb_ffa_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_ready = 1'b1;
    logic       arr_error = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] arr_dout = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_init, arr_wr, arr_rd, err_sticky, busy;
    logic [7:0] rsp_rdata, arr_din;
    logic [2:0] rsp_addr, arr_addr;

    int checks = 0;
    int errors = 0;

    ffa_cmd_sequencer dut (
        .clk (clk), .resetn (resetn),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_addr (rsp_addr), .rsp_init (rsp_init),
        .arr_wr (arr_wr), .arr_rd (arr_rd), .arr_addr (arr_addr), .arr_din (arr_din),
        .arr_dout (arr_dout), .arr_error (arr_error),
        .err_sticky (err_sticky), .err_clr (err_clr), .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Flip-flop array emulation: contents survive the sequencer's reset.
    logic [7:0] arr_mem [8];
    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;
    initial for (int i = 0; i < 8; i++) arr_mem[i] = 8'h00;
    always @(posedge clk) begin
        if (arr_wr) arr_mem[arr_addr] <= arr_din;
        if (arr_rd) arr_dout <= force_en ? force_val : arr_mem[arr_addr];
    end

    // Model: accepted-but-unissued commands, expected responses, array contents and written set.
    typedef struct packed { logic w; logic [2:0] a; logic [7:0] d; } cmd_t;
    typedef struct packed { logic [7:0] d; logic [2:0] a; logic i; } rsp_t;
    cmd_t       issue_q[$];
    rsp_t       exp_q[$];
    logic [7:0] model_mem [8];
    logic [7:0] model_wr = 8'h00;
    int         strobe_cnt = 0;
    int         wr_run = 0;
    int         wr_run_max = 0;
    logic       rdy_ok;
    initial for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) rdy_ok <= 1'b0;
        else         rdy_ok <= 1'b1;
    end

    always @(negedge clk) begin : monitor
        cmd_t c;
        rsp_t r;
        if (!resetn) begin
            issue_q.delete();
            exp_q.delete();
            model_wr = 8'h00;
            wr_run = 0;
            chk("reset_outputs", 32'({cmd_ready, rsp_valid, arr_wr, arr_rd, err_sticky, busy,
                                      rsp_rdata, rsp_addr, rsp_init, arr_addr, arr_din}), 32'd0);
        end else begin
            chk("wr_rd_exclusive", 32'(arr_wr & arr_rd), 32'd0);
            if (arr_wr || arr_rd) begin
                strobe_cnt++;
                if (issue_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(arr_wr | arr_rd), 32'd0);
                end else begin
                    c = issue_q.pop_front();
                    chk("strobe_kind", 32'(arr_wr), 32'(c.w));
                    chk("strobe_addr", 32'(arr_addr), 32'(c.a));
                    if (c.w) begin
                        chk("strobe_din", 32'(arr_din), 32'(c.d));
                        model_mem[c.a] = c.d;
                        model_wr[c.a]  = 1'b1;
                    end else begin
                        r.d = force_en ? force_val : model_mem[c.a];
                        r.a = c.a;
                        r.i = model_wr[c.a];
                        exp_q.push_back(r);
                    end
                end
            end
            if (arr_wr) wr_run++;
            else        wr_run = 0;
            if (wr_run > wr_run_max) wr_run_max = wr_run;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].d));
                    chk("rsp_addr",  32'(rsp_addr),  32'(exp_q[0].a));
                    chk("rsp_init",  32'(rsp_init),  32'(exp_q[0].i));
                end
            end
            chk("busy", 32'(busy), 32'((issue_q.size() > 0) || arr_wr || (exp_q.size() > 0)));
            chk("cmd_ready", 32'(cmd_ready), 32'(rdy_ok && (issue_q.size() < DEPTH)));
            if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) begin
                c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
                issue_q.push_back(c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one command until accepted; returns 2 time units after the accepting edge.
    task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d);
        int   n = 0;
        logic done = 1'b0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!done && n < 200) begin
            @(negedge clk);
            if (cmd_ready) done = 1'b1;
            @(posedge clk);
            #2;
            n++;
        end
        cmd_valid = 1'b0;
        chk("send_accept", 32'(done), 32'd1);
    endtask

    logic rnd_on;
    int   snap;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (2) step();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Read of unwritten address 3
        send(1'b0, 3'd3, 8'h00);
        @(negedge clk); chk("t1_rd_n0", 32'(arr_rd), 32'd0);
        @(negedge clk); chk("t1_rd_n1", 32'(arr_rd), 32'd1); chk("t1_addr", 32'(arr_addr), 32'd3);
        @(negedge clk); chk("t1_rd_n2", 32'(arr_rd), 32'd0); chk("t1_vld_n2", 32'(rsp_valid), 32'd0);
        @(negedge clk); chk("t1_vld_n3", 32'(rsp_valid), 32'd1);
        chk("t1_rdata", 32'(rsp_rdata), 32'h00); chk("t1_raddr", 32'(rsp_addr), 32'd3);
        chk("t1_init", 32'(rsp_init), 32'd0); chk("t1_err", 32'(err_sticky), 32'd0);
        repeat (4) step();

        // Write 5 <= A7, then read 5
        send(1'b1, 3'd5, 8'hA7);
        send(1'b0, 3'd5, 8'h00);
        @(negedge clk); chk("t2_wr", 32'(arr_wr), 32'd1);
        chk("t2_addr", 32'(arr_addr), 32'd5); chk("t2_din", 32'(arr_din), 32'hA7);
        @(negedge clk); chk("t2_wr_off", 32'(arr_wr), 32'd0); chk("t2_rd", 32'(arr_rd), 32'd1);
        @(negedge clk); chk("t2_vld_early", 32'(rsp_valid), 32'd0);
        @(negedge clk); chk("t2_vld", 32'(rsp_valid), 32'd1);
        chk("t2_rdata", 32'(rsp_rdata), 32'hA7); chk("t2_init", 32'(rsp_init), 32'd1);
        repeat (4) step();

        // Four back-to-back writes
        wr_run_max = 0;
        send(1'b1, 3'd0, 8'h10);
        send(1'b1, 3'd1, 8'h21);
        send(1'b1, 3'd2, 8'h32);
        send(1'b1, 3'd4, 8'h54);
        repeat (6) step();
        chk("t3_wr_run", 32'(wr_run_max), 32'd4);

        // Hold a response and fill the FIFO behind it
        rsp_ready = 1'b0;
        send(1'b0, 3'd1, 8'h00);
        send(1'b1, 3'd6, 8'h11);
        send(1'b0, 3'd6, 8'h00);
        send(1'b1, 3'd7, 8'h22);
        send(1'b0, 3'd0, 8'h00);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd3; cmd_wdata = 8'h33;
        snap = strobe_cnt;
        repeat (4) step();
        chk("t3_full", 32'(cmd_ready), 32'd0);
        chk("t3_hold_vld", 32'(rsp_valid), 32'd1);
        chk("t3_hold_data", 32'(rsp_rdata), 32'h21);
        chk("t3_no_strobe", 32'(strobe_cnt - snap), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        send(1'b1, 3'd3, 8'h33);
        repeat (20) step();
        chk("t3_drained", 32'(strobe_cnt - snap), 32'd5);
        chk("t3_idle", 32'(busy), 32'd0);

        // Random traffic with a random response consumer
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    step();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (40) step();
        chk("rnd_idle", 32'(busy), 32'd0);

        // Sticky error flag
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t5_cleared", 32'(err_sticky), 32'd0);
        arr_error = 1'b1; step(); arr_error = 1'b0;
        chk("t5_set", 32'(err_sticky), 32'd1);
        repeat (3) step();
        chk("t5_sticky", 32'(err_sticky), 32'd1);
        err_clr = 1'b1; arr_error = 1'b1; step(); err_clr = 1'b0; arr_error = 1'b0;
        chk("t5_set_wins", 32'(err_sticky), 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t5_clr", 32'(err_sticky), 32'd0);

        // Nonzero data from an unwritten address after reset
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        repeat (3) step();
        force_en = 1'b1; force_val = 8'h3C;
        send(1'b0, 3'd7, 8'h00);
        repeat (3) @(negedge clk);
        @(negedge clk); chk("t6_vld", 32'(rsp_valid), 32'd1);
        chk("t6_rdata", 32'(rsp_rdata), 32'h3C); chk("t6_init", 32'(rsp_init), 32'd0);
        chk("t6_err", 32'(err_sticky), 32'd1);
        repeat (4) step();
        force_en = 1'b0;

        // Reset during CAPT with three commands queued
        send(1'b1, 3'd2, 8'h5A);
        repeat (4) step();
        rsp_ready = 1'b0;
        send(1'b0, 3'd1, 8'h00);
        send(1'b0, 3'd2, 8'h00);
        send(1'b1, 3'd3, 8'h44);
        send(1'b1, 3'd5, 8'h55);
        send(1'b0, 3'd6, 8'h00);
        repeat (3) step();
        rsp_ready = 1'b1;
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("t7_rsp_vld", 32'(rsp_valid), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_rd", 32'(arr_rd), 32'd0);
        repeat (2) step();
        resetn = 1'b1;
        snap = strobe_cnt;
        repeat (5) step();
        chk("t7_no_strobe", 32'(strobe_cnt - snap), 32'd0);
        send(1'b0, 3'd2, 8'h00);
        repeat (3) @(negedge clk);
        @(negedge clk); chk("t7_vld", 32'(rsp_valid), 32'd1);
        chk("t7_init", 32'(rsp_init), 32'd0); chk("t7_rdata", 32'(rsp_rdata), 32'h5A);
        chk("t7_err", 32'(err_sticky), 32'd1);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
